// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staggered per-domain reset sequencer with soft-reset handshake
// Optional macro RST_SEQ_CAUSE_EN adds rst_cause (0 = board reset, 1 = soft reset).
module rst_sequencer #(
    parameter int N_DOMAINS      = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 8,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 soft_req,
    output logic                 soft_ack,
    output logic [N_DOMAINS-1:0] rst_n_out,
    output logic                 rst_done,
`ifdef RST_SEQ_CAUSE_EN
    output logic                 rst_cause,
`endif
    output logic                 busy
);

    localparam int MAXC = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(N_DOMAINS) + 1;

    localparam logic [CW-1:0] S_LOAD = CW'(STRETCH_CYCLES - 1);
    localparam logic [CW-1:0] G_LOAD = CW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0] LAST   = IW'(N_DOMAINS - 1);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_STRETCH = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_n;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_DOMAINS-1:0]   rst_n_q, rst_n_d;
    logic                   ack_q, ack_d;
    logic                   soft_act_q, soft_act_d;
    logic                   done_q, busy_q;
    logic                   enter_done;

    assign sync_n = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        rst_n_d    = rst_n_q;
        ack_d      = ack_q;
        soft_act_d = soft_act_q;
        enter_done = 1'b0;
        case (state_q)
            ST_ASSERT: begin
                if (sync_n) begin
                    state_d = ST_STRETCH;
                    cnt_d   = S_LOAD;
                end
            end
            ST_STRETCH: begin
                if (cnt_q == '0) begin
                    rst_n_d[0] = 1'b1;
                    if (N_DOMAINS == 1) begin
                        enter_done = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IW'(1);
                        cnt_d   = G_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == '0) begin
                    for (int i = 0; i < N_DOMAINS; i++) begin
                        if (idx_q == IW'(i)) rst_n_d[i] = 1'b1;
                    end
                    if (idx_q == LAST) begin
                        enter_done = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        cnt_d = G_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                // Ack stays up until the requester drops soft_req, blocking retrigger.
                if (soft_req && !ack_q) begin
                    state_d    = ST_STRETCH;
                    cnt_d      = S_LOAD;
                    idx_d      = '0;
                    rst_n_d    = '0;
                    soft_act_d = 1'b1;
                end else if (!soft_req) begin
                    ack_d = 1'b0;
                end
            end
        endcase
        if (enter_done) begin
            state_d    = ST_DONE;
            rst_n_d    = '1;
            ack_d      = soft_act_q;
            soft_act_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            state_q    <= ST_ASSERT;
            cnt_q      <= '0;
            idx_q      <= '0;
            rst_n_q    <= '0;
            ack_q      <= 1'b0;
            soft_act_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rst_n_q    <= rst_n_d;
            ack_q      <= ack_d;
            soft_act_q <= soft_act_d;
            done_q     <= (state_d == ST_DONE);
            busy_q     <= (state_d != ST_DONE);
        end
    end

`ifdef RST_SEQ_CAUSE_EN
    logic cause_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cause_q <= 1'b0;
        end else if (enter_done) begin
            cause_q <= soft_act_q;
        end
    end

    assign rst_cause = cause_q;
`endif

    assign rst_n_out = rst_n_q;
    assign rst_done  = done_q;
    assign busy      = busy_q;
    assign soft_ack  = ack_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Reset controller for the lab flip-flop datapaths. Takes the board-level asynchronous active-low reset and produces per-domain active-low resets.
- Each domain reset asserts asynchronously and deasserts synchronously to clk.
- Release is staggered: one domain at a time, in index order.
- A synchronous soft-reset request, with a four-phase handshake, re-runs the sequence without touching the board reset.

Parameters:
- N_DOMAINS, 4: number of reset domains (>=1).
- SYNC_STAGES, 2: depth of the reset-deassert synchronizer chain (>=2).
- STRETCH_CYCLES, 8: clk edges all domains stay in reset after the sequence starts (>=1).
- GAP_CYCLES, 4: clk edges between consecutive domain releases (>=1).

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- soft_req  input  1  synchronous soft-reset request (level, four-phase).
- soft_ack  output  1  soft-reset completion acknowledge.
- rst_n_out  output  N_DOMAINS  per-domain active-low resets; bit 0 is released first.
- rst_done  output  1  all domains released.
- busy  output  1  sequence in progress (state != DONE).

Behaviour:
- Interface (already decided): one clock, clk. reset is asynchronous and active-low.
- reset=0 immediately, without waiting for a clock edge, forces:
  - rst_n_out = all 0
  - rst_done = 0
  - soft_ack = 0
  - busy = 1
  - synchronizer chain = all 0
  - FSM = ASSERT
  - counters = 0
- Synchronizer:
  - SYNC_STAGES flops, input tied to 1, cleared asynchronously by reset.
  - Output sync_n reaches 1 on the SYNC_STAGES-th rising edge after reset deasserts.
- FSM states: ASSERT, STRETCH, RELEASE, DONE.
  - ASSERT: all rst_n_out = 0. Moves to STRETCH on the edge where sync_n is sampled as 1, which is edge SYNC_STAGES+1. Entering STRETCH loads the cycle counter.
  - STRETCH: all domains held in reset. On the STRETCH_CYCLES-th edge after entering STRETCH, rst_n_out[0] goes to 1.
    - If N_DOMAINS=1: go directly to DONE on that edge.
    - Otherwise: go to RELEASE with domain index = 1.
  - RELEASE: every GAP_CYCLES edges, set rst_n_out[index] to 1 and increment index. The edge that releases domain N_DOMAINS-1 also enters DONE.
  - DONE: rst_done = 1, busy = 0, rst_n_out = all 1.
- Release order:
  - Once released, a domain stays released until the next sequence start.
  - Released bits are never deasserted out of order.
- Timing with defaults, edges counted from reset deassert:
  - rst_n_out[0] at edge 11, [1] at edge 15, [2] at edge 19, [3] at edge 23.
  - rst_done at edge 23.
- Soft reset:
  - Sampled only in DONE. A request is accepted on edge E when soft_req=1 and soft_ack=0.
  - From the registered outputs after edge E: rst_n_out = all 0, rst_done = 0, busy = 1, FSM = STRETCH with the counter loaded. The synchronizer is not re-run.
  - Release timing is then identical to power-on, counted from E: domain i at edge E + STRETCH_CYCLES + i*GAP_CYCLES.
  - soft_ack rises on the same edge that enters DONE for a soft-initiated sequence.
  - soft_ack is held while soft_req=1 and falls on the edge after soft_req=0 is sampled.
  - While soft_ack=1, soft_req does not retrigger.
- soft_req is ignored in ASSERT, STRETCH and RELEASE. It is not latched, so the requester must hold it.
- Board reset during any state, including mid-soft-sequence: immediate async return to ASSERT, soft_ack cleared, pending handshake discarded.
- Outputs are registered; no combinational path from soft_req to any output.
- Counter widths: $clog2 of max(STRETCH_CYCLES, GAP_CYCLES)+1. The index counter is $clog2(N_DOMAINS)+1 wide.

Optional Feature:
- Macro: RST_SEQ_CAUSE_EN.
- When defined, adds output port rst_cause (1 bit) recording what started the last completed sequence: 0 = board reset, 1 = soft reset.
  - Async-cleared to 0 by reset.
  - Updated on the edge that enters DONE.
  - Holds its value in all other states.
- When undefined, the port and its flop are absent and behaviour is otherwise identical.

Test Plan:
- Power-on, defaults: reset low 3 cycles, then high. Require:
  - rst_n_out = 0000 through edge 10
  - rst_n_out = 0001 at 11, 0011 at 15, 0111 at 19, 1111 at 23
  - rst_done = 1 and busy = 0 at 23
- Async assert: in DONE, drop reset mid-cycle. rst_n_out = 0000, rst_done = 0 and busy = 1 before the next clk edge, then the full power-on timing repeats.
- Soft reset: in DONE, assert soft_req at edge E. Require:
  - rst_n_out = 0000 after E
  - releases at E+8, E+12, E+16, E+20
  - soft_ack = 1 at E+20
  - soft_req held high 5 more cycles: no retrigger
  - soft_req dropped: soft_ack = 0 one edge later
- Ignored request: pulse soft_req during RELEASE. No restart and soft_ack stays 0; after DONE, soft_req = 0 leaves the outputs unchanged.
- Reset mid-soft-sequence: board reset at E+14. Immediate rst_n_out = 0000 and soft_ack never asserts; with RST_SEQ_CAUSE_EN, rst_cause = 0 after the following DONE.
- Parameter corner: N_DOMAINS=1, STRETCH_CYCLES=1, SYNC_STAGES=2. rst_n_out = 1 and rst_done = 1 at edge 4 after reset deassert.
